// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of a word-organised SRAM array.
// Supports byte/halfword/word accesses, fixed wait states and the two-cycle ERROR response.
module ahb_sram_subordinate #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hsel_i,
    input  logic [31:0] haddr_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic [31:0] hwdata_i,
    input  logic        hready_i,
    output logic        hreadyout_o,
    output logic        hresp_o,
    output logic [31:0] hrdata_o
);

    localparam int unsigned IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [33:0] SpanBytes = 34'(DEPTH) << 2;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StWait = 3'd1;
    localparam logic [2:0] StData = 3'd2;
    localparam logic [2:0] StErr1 = 3'd3;
    localparam logic [2:0] StErr2 = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;

    logic [31:0] mem_q [DEPTH];

    logic        accept;
    logic        req_legal;
    logic [33:0] req_off;
    logic [31:0] cur_off;
    logic [IdxW-1:0] word_idx;
    logic [3:0]  byte_en;
    logic        unused_htrans;

    assign unused_htrans = htrans_i[0];

    // Widened subtraction: addresses below BASE_ADDR land far above SpanBytes.
    assign req_off = {2'b00, haddr_i} - {2'b00, BASE_ADDR};

    always_comb begin
        req_legal = (haddr_i >= BASE_ADDR) && (req_off < SpanBytes);
        case (hsize_i)
            3'd0:    req_legal = req_legal;
            3'd1:    req_legal = req_legal && !haddr_i[0];
            3'd2:    req_legal = req_legal && (haddr_i[1:0] == 2'b00);
            default: req_legal = 1'b0;
        endcase
    end

    assign accept = hsel_i && hready_i && htrans_i[1] && hreadyout_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1: state_d = StErr2;
            default: begin
                state_d = StIdle;
                if (accept) begin
                    addr_d  = haddr_i;
                    write_d = hwrite_i;
                    size_d  = hsize_i;
                    if (!req_legal) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = StData;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    assign cur_off  = addr_q - BASE_ADDR;
    assign word_idx = IdxW'(cur_off >> 2);

    always_comb begin
        case (size_q)
            3'd0:    byte_en = 4'b0001 << addr_q[1:0];
            3'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Write commits at the edge closing DATA, so a following read sees it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_q == StData) && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][8*b +: 8] <= hwdata_i[8*b +: 8];
                end
            end
        end
    end

    assign hreadyout_o = (state_q != StWait) && (state_q != StErr1);
    assign hresp_o     = (state_q == StErr1) || (state_q == StErr2);
    assign hrdata_o    = ((state_q == StData) && !write_q) ? mem_q[word_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed bench: three subordinates (0, 3 and 2 wait states) on one driven bus,
// checked cycle by cycle against a transfer-level model.
module tb_ahb_sram_subordinate;

    localparam logic [31:0] B = 32'h0000_1000;
    localparam int unsigned D = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = '0;
    int          sel = 0;

    logic        rdy_w [3];
    logic        rsp_w [3];
    logic [31:0] rd_w  [3];

    always #5 clk = ~clk;

    ahb_sram_subordinate #(.BASE_ADDR(B), .DEPTH(D), .WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .rst_i(rst), .hsel_i(hsel && sel == 0), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata),
        .hready_i(rdy_w[0]), .hreadyout_o(rdy_w[0]), .hresp_o(rsp_w[0]), .hrdata_o(rd_w[0])
    );
    ahb_sram_subordinate #(.BASE_ADDR(B), .DEPTH(D), .WAIT_STATES(3)) u_ws3 (
        .clk_i(clk), .rst_i(rst), .hsel_i(hsel && sel == 1), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata),
        .hready_i(rdy_w[1]), .hreadyout_o(rdy_w[1]), .hresp_o(rsp_w[1]), .hrdata_o(rd_w[1])
    );
    ahb_sram_subordinate #(.BASE_ADDR(B), .DEPTH(D), .WAIT_STATES(2)) u_ws2 (
        .clk_i(clk), .rst_i(rst), .hsel_i(hsel && sel == 2), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata),
        .hready_i(rdy_w[2]), .hreadyout_o(rdy_w[2]), .hresp_o(rsp_w[2]), .hrdata_o(rd_w[2])
    );

    typedef struct packed {
        logic        rdy;
        logic        rsp;
        logic [31:0] rd;
        logic        isrd;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        cmp_e;
    logic [7:0]  mdl [int];
    int          total = 0;
    int          bad = 0;
    bit          chk_en = 1'b0;
    logic [31:0] last_rd = '0;
    logic [31:0] last_exp_rd = '0;
    int          low_run = 0;
    int          last_low = 0;
    logic [31:0] pend_wd = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : (s == 1) ? 3 : 2;
    endfunction

    function automatic int key(input int s, input longint unsigned off);
        return s * 65536 + int'(off);
    endfunction

    task automatic push(input logic r, input logic p, input logic [31:0] d, input logic isrd);
        exp_t e;
        e.rdy = r; e.rsp = p; e.rd = d; e.isrd = isrd;
        exp_q.push_back(e);
    endtask

    // Transfer-level model: what the data phase of an accepted address phase must look like.
    task automatic model_accept(input logic s, input logic [1:0] tr, input logic w,
                                input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        longint unsigned la, off;
        int unsigned     n;
        logic [31:0]     word;
        bit              legal;
        if (!(s && tr[1])) begin
            push(1'b1, 1'b0, 32'h0, 1'b0);
            return;
        end
        la = a;
        if (sz > 3'd2) legal = 0;
        else legal = (la >= B) && (la < longint'(B) + 4 * D) && ((la % (1 << sz)) == 0);
        if (!legal) begin
            push(1'b0, 1'b1, 32'h0, 1'b0);
            push(1'b1, 1'b1, 32'h0, 1'b0);
            return;
        end
        for (int i = 0; i < ws_of(sel); i++) push(1'b0, 1'b0, 32'h0, 1'b0);
        off = la - B;
        n = 1 << sz;
        if (w) begin
            for (int i = 0; i < int'(n); i++)
                mdl[key(sel, off + i)] = wd[8 * ((off + i) % 4) +: 8];
            push(1'b1, 1'b0, 32'h0, 1'b0);
        end else begin
            off = off & ~longint'(3);
            for (int i = 0; i < 4; i++)
                word[8*i +: 8] = mdl.exists(key(sel, off + i)) ? mdl[key(sel, off + i)] : 8'h00;
            push(1'b1, 1'b0, word, 1'b1);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic xfer(input logic s, input logic [1:0] tr, input logic w, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
        int guard = 0;
        hsel = s; htrans = tr; hwrite = w; hsize = sz; haddr = a; hwdata = pend_wd;
        while (!rdy_w[sel] && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) check("hready_timeout", 64'(guard), 64'd0);
        @(posedge clk);
        model_accept(s, tr, w, sz, a, wd);
        pend_wd = wd;
        @(negedge clk);
    endtask

    task automatic idle_gap();
        xfer(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic pin_rd(input string nm, input logic [31:0] want);
        check({nm, "_model"}, {32'h0, last_exp_rd}, {32'h0, want});
        check({nm, "_dut"}, {32'h0, last_rd}, {32'h0, want});
    endtask

    always @(negedge clk) begin
        if (chk_en && exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            check("cycle", {30'h0, rdy_w[sel], rsp_w[sel], rd_w[sel]},
                  {30'h0, cmp_e.rdy, cmp_e.rsp, cmp_e.rd});
            if (cmp_e.isrd) begin
                last_rd = rd_w[sel];
                last_exp_rd = cmp_e.rd;
            end
            if (!rdy_w[sel]) begin
                low_run++;
            end else begin
                if (low_run > 0) last_low = low_run;
                low_run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    localparam logic [1:0] Idle = 2'b00, Busy = 2'b01, NonSeq = 2'b10;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check("reset", {30'h0, rdy_w[k], rsp_w[k], rd_w[k]}, {30'h0, 1'b1, 1'b0, 32'h0});
        rst = 1'b0;
        chk_en = 1'b1;

        // Zero wait states: write then read back-to-back.
        xfer(1'b1, NonSeq, 1'b1, 3'd2, B + 32'h10, 32'hDEAD_BEEF);
        xfer(1'b1, NonSeq, 1'b0, 3'd2, B + 32'h10, 32'h0);
        idle_gap();
        pin_rd("b2b_read", 32'hDEAD_BEEF);

        // Sub-word merge.
        xfer(1'b1, NonSeq, 1'b1, 3'd2, B + 32'h20, 32'h1122_3344);
        xfer(1'b1, NonSeq, 1'b1, 3'd0, B + 32'h21, 32'h0000_AA00);
        xfer(1'b1, NonSeq, 1'b1, 3'd1, B + 32'h22, 32'hBBCC_0000);
        xfer(1'b1, NonSeq, 0, 3'd2, B + 32'h20, 32'h0);
        idle_gap();
        pin_rd("subword", 32'hBBCC_AA44);

        // Illegal transfers must not touch the array.
        xfer(1'b1, NonSeq, 1'b1, 3'd2, B, 32'h5566_7788);
        xfer(1'b1, NonSeq, 1'b0, 3'd2, B + 32'h2, 32'h0);
        xfer(1'b1, NonSeq, 1'b1, 3'd1, B + 4 * D, 32'h1111_2222);
        xfer(1'b1, NonSeq, 1'b1, 3'd3, B, 32'hFFFF_FFFF);
        xfer(1'b1, NonSeq, 1'b1, 3'd2, B - 32'h4, 32'h9999_9999);
        xfer(1'b1, NonSeq, 1'b1, 3'd0, B + 4 * D - 1 + 32'h1, 32'h0000_00EE);
        xfer(1'b1, NonSeq, 1'b0, 3'd2, B, 32'h0);
        idle_gap();
        pin_rd("err_nowrite", 32'h5566_7788);

        // IDLE/BUSY selected and NONSEQ unselected are no-ops.
        xfer(1'b1, Idle, 1'b1, 3'd2, B, 32'hAAAA_AAAA);
        xfer(1'b1, Busy, 1'b1, 3'd2, B, 32'hBBBB_BBBB);
        xfer(1'b0, NonSeq, 1'b1, 3'd2, B, 32'hCCCC_CCCC);
        xfer(1'b1, NonSeq, 1'b0, 3'd2, B, 32'h0);
        idle_gap();
        pin_rd("noop_nowrite", 32'h5566_7788);

        // Three wait states; the read is presented while the write is still waiting.
        sel = 1;
        xfer(1'b1, NonSeq, 1'b1, 3'd2, B + 32'h8, 32'h1234_5678);
        xfer(1'b1, NonSeq, 1'b0, 3'd2, B + 32'h8, 32'h0);
        idle_gap();
        pin_rd("ws3_read", 32'h1234_5678);
        check("ws3_low_cycles", 64'(last_low), 64'd3);

        // Two wait states; reset in the middle of a write aborts it.
        sel = 2;
        xfer(1'b1, NonSeq, 1'b1, 3'd2, B + 32'h30, 32'hCAFE_F00D);
        xfer(1'b1, NonSeq, 1'b0, 3'd2, B + 32'h30, 32'h0);
        idle_gap();
        pin_rd("ws2_read", 32'hCAFE_F00D);

        hsel = 1'b1; htrans = NonSeq; hwrite = 1'b1; hsize = 3'd2; haddr = B + 32'h30;
        hwdata = pend_wd;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        hsel = 1'b0; htrans = Idle; hwdata = 32'h0BAD_0BAD;
        check("ws2_in_wait", {63'h0, rdy_w[2]}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_abort", {30'h0, rdy_w[2], rsp_w[2], rd_w[2]}, {30'h0, 1'b1, 1'b0, 32'h0});
        rst = 1'b0;
        exp_q.delete();
        pend_wd = '0;
        low_run = 0;
        chk_en = 1'b1;
        xfer(1'b1, NonSeq, 1'b0, 3'd2, B + 32'h30, 32'h0);
        idle_gap();
        pin_rd("rst_kept_old", 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_subordinate.md
Name: ahb_sram_subordinate

Overview:
- AHB-Lite subordinate fronting an internal word-organised SRAM array. It is the responder counterpart to the core's AHB-Lite instruction/data managers.
- Sits on the interconnect behind the address decoder, which drives hsel.
- Supports byte, halfword and word accesses, programmable wait states, and the two-cycle ERROR response for illegal transfers.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of array word 0; must be 4-byte aligned.
- DEPTH, 1024, number of 32-bit words in the array.
- WAIT_STATES, 0, extra data-phase cycles with hreadyout=0 per legal transfer (0..15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- hsel  input  1  subordinate select from decoder.
- haddr  input  32  byte address (address phase).
- htrans  input  2  transfer type, htrans_t encoding (IDLE/BUSY/NONSEQ/SEQ).
- hwrite  input  1  1=write, 0=read (address phase).
- hsize  input  3  0=byte, 1=halfword, 2=word; others illegal.
- hwdata  input  32  write data (data phase).
- hready  input  1  bus-level ready; an address phase is taken only when high.
- hreadyout  output  1  this subordinate's data-phase ready.
- hresp  output  1  0=OKAY, 1=ERROR.
- hrdata  output  32  read data, valid when hreadyout=1 in a read data phase.

Behaviour:
- Reset (rst=1 at edge): state IDLE, hreadyout=1, hresp=0, hrdata=0, captured phase registers cleared. Array contents are not reset. Reset during WAIT or ERR aborts the transfer; no array write occurs.
- Address phase is accepted when hsel & hready & htrans[1] (NONSEQ or SEQ). The subordinate then registers addr_q, write_q, size_q and the legality result.
- hsel & hready with IDLE or BUSY, or hsel=0: next cycle is a zero-wait OKAY data phase (hreadyout=1, hresp=0). No array access.
- A transfer is illegal if any of the following holds:
  - haddr is outside [BASE_ADDR, BASE_ADDR+4*DEPTH).
  - hsize > 2.
  - A halfword access has haddr[0]=1.
  - A word access has haddr[1:0]!=0.
- State machine:
  - IDLE: hreadyout=1.
    - Accepted legal transfer with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
    - Accepted legal transfer with WAIT_STATES=0 -> DATA.
    - Accepted illegal transfer -> ERR1.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle; at 0 -> DATA.
  - DATA: hreadyout=1, hresp=0. The transfer completes this cycle. The next state follows the same rules as IDLE for a new address phase sampled this cycle; with no new transfer -> IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1. New address phase handled as in IDLE.
- Legal-transfer latency: address phase + (1+WAIT_STATES) data-phase cycles.
- Read: hrdata = mem[(addr_q-BASE_ADDR)>>2], full word returned combinationally from the registered address during DATA. The manager selects byte lanes. hrdata=0 in all non-read-DATA cycles.
- Write: at the rising edge ending DATA, hwdata is written under byte enables.
  - Byte: lane addr_q[1:0].
  - Halfword: lanes {addr_q[1],0} and {addr_q[1],1}.
  - Word: all four lanes.
  - Unselected lanes are unchanged. Illegal transfers never write.
- Back-to-back write then read of the same word returns the newly written data, because the write commits before the read's DATA cycle.
- While hreadyout=0, address-phase inputs are ignored; the bus holds hready=0.
- Word index arithmetic is 32-bit unsigned. The out-of-range check must not wrap for addresses below BASE_ADDR.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF @BASE+0x10, then read @BASE+0x10 back-to-back -> write DATA hreadyout=1/OKAY; read DATA hrdata=0xDEADBEEF one cycle after read address phase.
- Sub-word: word 0x11223344 @0x20; byte write 0xAA @0x21; halfword write 0xBBCC @0x22; read @0x20 -> 0xBBCCAA44.
- WAIT_STATES=3: single read -> hreadyout low exactly 3 cycles, high on 4th with correct hrdata; new NONSEQ held during wait is accepted only when hready=1.
- Errors: word read @BASE+0x2; halfword @BASE+4*DEPTH; hsize=3 -> each gives hreadyout=0/hresp=1, then hreadyout=1/hresp=1; array unchanged (read-back of prior contents).
- IDLE/BUSY with hsel=1, and NONSEQ with hsel=0 -> zero-wait OKAY, no array write, hrdata=0.
- Assert rst during WAIT of a write (WAIT_STATES=2) -> next cycle hreadyout=1, hresp=0; location retains old value.
